seq_multiplier: RTL
===================

# seq_multiplier

Parametrised sequential shift-add multiplier with a nibble-wide load/read bus and signed/unsigned mode. It generalises the fixed 4x4 unsigned multiplier to WIDTH x WIDTH operands. It adds an explicit START/BUSY/DONE handshake, indexed nibble access to operands and product, and two's-complement signed multiplication. It sits on the core's 4-bit data path as a coprocessor and is clocked from the same clock as the multiplier unit.

## Interface
- WIDTH, 8, operand width in bits. Multiple of 4, minimum 4. Product is 2*WIDTH bits.
- IW, $clog2(WIDTH/2), nibble index width (derived, not overridden). Product holds WIDTH/2 nibbles.

Ports:
- MUL_CLK  in  1  clock; all state changes on rising edge
- RST_N  in  1  reset; asynchronous, active-low
- DIN  in  4  nibble to load
- LOAD  in  1  write DIN into operand nibble IDX of operand selected by OPSEL
- OPSEL  in  1  0 = multiplicand A, 1 = multiplier B
- IDX  in  IW  nibble index: operand nibble on LOAD, product nibble on R
- START  in  1  begin multiplication of current A, B
- SIGNED  in  1  1 = two's-complement operands; sampled only at START
- R  out  4  product nibble IDX (combinational from product register)
- BUSY  out  1  multiplication in progress
- DONE  out  1  one-cycle pulse when product is final

## Operation
- Registers: A[WIDTH-1:0], B[WIDTH-1:0], P[2*WIDTH-1:0], step counter, latched mode bit, state.
- States: IDLE, RUN.
- IDLE:
  - LOAD with IDX < WIDTH/4 writes DIN into bits [4*IDX+3:4*IDX] of A or B.
  - LOAD with IDX >= WIDTH/4 is ignored.
  - START with LOAD low: P <= {WIDTH'b0, B}, counter <= WIDTH, mode <= SIGNED, go to RUN.
- RUN, one step per edge:
  - Let H = P[2W-1:W] extended to W+1 bits (sign-extended if mode=1, zero-extended otherwise).
  - If P[0]=1: H <= H + ext(A). On the final step with mode=1, use H - ext(A) instead, since the multiplier MSB has negative weight.
  - P <= {H, P[W-1:1]}: shifted right by 1, with H's top bit entering the MSB.
  - Counter decrements. When it reaches 0, go to IDLE.
- A and B persist after an operation. A second START recomputes without reloading.
- Arithmetic: the W+1-bit intermediate is used so no overflow is lost. The final P is the exact 2W-bit product, two's-complement when mode=1.
- R always equals P[4*IDX+3:4*IDX], including during RUN, where it shows intermediate values.

## Timing
- Reset (RST_N low, asynchronous): A, B, P, counter = 0; state = IDLE; BUSY = 0, DONE = 0, R = 0.
- START sampled at edge 0 → BUSY = 1 from edge 0 through edge WIDTH.
- Steps execute at edges 1..WIDTH.
- At edge WIDTH: BUSY falls, DONE = 1 for exactly one cycle, and P is final.
- Total latency: WIDTH+1 edges from START to result.
- The earliest next START is accepted in the cycle DONE is high, i.e. back-to-back operations are allowed.
- START while BUSY: ignored, no restart.
- LOAD while BUSY: ignored; operands are unchanged.
- LOAD and START in the same IDLE cycle: LOAD takes effect, START is ignored.
- SIGNED changes during RUN have no effect.
- RST_N asserted mid-RUN: immediate abort to reset values. DONE never pulses for the aborted operation.
- RST_N deassertion is synchronised externally; the block needs no edge after release before accepting LOAD.

## Test plan
- WIDTH=8, unsigned: A=0xFF, B=0xFF, START → DONE at edge 8, BUSY high 8 cycles; R for IDX 0..3 = 1,0,E,F (P=0xFE01).
- WIDTH=8, signed: A=0x80, B=0x80 → P=0x4000. Then A=0xFD (-3), B=0x05 → P=0xFFF1. Then A=0x80, B=0x7F → P=0xC080.
- WIDTH=8, same operands 0xFD x 0x05 with SIGNED=0 → P=0x04F1. Reissue START without reload → identical P.
- START pulsed again at edge 3 of RUN, plus LOAD A=0x0 during RUN → ignored. DONE still at edge 8 and result unchanged.
- RST_N low at edge 4 of RUN → BUSY=0, R=0 immediately, A=B=0, no DONE pulse. A new load+START completes normally.
- WIDTH=4 instance, unsigned 0xF x 0xF → P=0xE1, DONE at edge 4. Signed 0x8 x 0x8 → P=0x40. LOAD with IDX=1 is ignored.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with nibble-wide
// operand load / product read and optional two's-complement operation.
module seq_multiplier #(
  parameter  int WIDTH = 8,
  localparam int IW    = $clog2(WIDTH/2)
) (
  input  logic          MUL_CLK,
  input  logic          RST_N,
  input  logic [3:0]    DIN,
  input  logic          LOAD,
  input  logic          OPSEL,
  input  logic [IW-1:0] IDX,
  input  logic          START,
  input  logic          SIGNED,
  output logic [3:0]    R,
  output logic          BUSY,
  output logic          DONE
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH:0]       h_s;
  logic [WIDTH:0]       ext_a_s;

  // Next-state, operand load and one shift-add step per cycle
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    h_s     = {1'b0, p_q[2*WIDTH-1:WIDTH]};
    ext_a_s = {1'b0, a_q};
    case (state_q)
      IDLE: begin
        for (int i = 0; i < WIDTH/4; i++) begin
          a_d[4*i +: 4] = (LOAD && !OPSEL && (IDX == IW'(i))) ? DIN : a_q[4*i +: 4];
          b_d[4*i +: 4] = (LOAD &&  OPSEL && (IDX == IW'(i))) ? DIN : b_q[4*i +: 4];
        end
        // LOAD wins over START when both are asserted together
        if (START && !LOAD) begin
          p_d     = {{WIDTH{1'b0}}, b_q};
          cnt_d   = CNT_INIT;
          mode_d  = SIGNED;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (mode_q) begin
          h_s     = {p_q[2*WIDTH-1], p_q[2*WIDTH-1:WIDTH]};
          ext_a_s = {a_q[WIDTH-1], a_q};
        end else begin
          h_s     = {1'b0, p_q[2*WIDTH-1:WIDTH]};
          ext_a_s = {1'b0, a_q};
        end
        // In signed mode the multiplier MSB carries negative weight
        if (p_q[0]) begin
          if (mode_q && (cnt_q == CNT_LAST)) begin
            h_s = h_s - ext_a_s;
          end else begin
            h_s = h_s + ext_a_s;
          end
        end else begin
          h_s = h_s;
        end
        p_d   = {h_s, p_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  // State and datapath registers
  always_ff @(posedge MUL_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      p_q     <= {(2*WIDTH){1'b0}};
      cnt_q   <= {CW{1'b0}};
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Product nibble read mux; out-of-range indices read as zero
  always_comb begin
    R = 4'h0;
    for (int i = 0; i < WIDTH/2; i++) begin
      R = (IDX == IW'(i)) ? p_q[4*i +: 4] : R;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
